// File: rtl/stall_pipeline.sv
// stall_pipeline: DEPTH-stage valid/ready pipeline with bubble-collapsing backpressure.
// Optional synchronous flush port enabled by defining STALL_PIPE_FLUSH_EN.
module stall_pipeline #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef STALL_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [DEPTH-1:0] r_v;
    logic [CNT_W-1:0] r_occ;
    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_uv;
    logic [WIDTH-1:0] w_ud [DEPTH];
    logic             w_flush;
    logic             w_in_hs;
    logic             w_out_hs;

`ifdef STALL_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A stage may load whenever it is empty or everything below it is moving.
    always_comb begin
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            w_rdy[i] = ~r_v[i] | w_rdy[i+1];
        w_uv[0] = in_valid;
        w_ud[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_uv[i] = r_v[i-1];
            w_ud[i] = r_d[i-1];
        end
    end

    assign in_ready  = w_rdy[0] & ~rst & ~w_flush;
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = r_occ;
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_d[i] <= '0;
        end else if (w_flush) begin
            r_v   <= '0;
            r_occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_v[i] <= w_uv[i];
                    if (w_uv[i])
                        r_d[i] <= w_ud[i];
                end
            end
            r_occ <= r_occ + CNT_W'(w_in_hs) - CNT_W'(w_out_hs);
        end
    end
endmodule

// File: tb/tb_stall_pipeline.sv
// tb_stall_pipeline: randomized and directed checks of stall_pipeline against a
// word-position reference model (each word tracks which stage it occupies).
module tb_stall_pipeline;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] occupancy;
`ifdef STALL_PIPE_FLUSH_EN
    logic             flush = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] m_d[$];
    int               m_p[$];

    stall_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
`ifdef STALL_PIPE_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check against the model, then advance the model.
    // Words move forward one stage unless the next older word blocks them.
    task automatic step(input bit iv, input logic [WIDTH-1:0] id, input bit ordy, output bit acc);
        bit exp_ir, exp_ov;
        int lim;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        exp_ir = (m_p.size() < DEPTH) || ordy;
        exp_ov = (m_p.size() > 0) && (m_p[0] == DEPTH - 1);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("occupancy", 32'(occupancy), 32'(m_p.size()));
        if (exp_ov) chk("out_data", 32'(out_data), 32'(m_d[0]));
        acc = iv && exp_ir;
        lim = ordy ? DEPTH + 1 : DEPTH;
        foreach (m_p[i]) begin
            m_p[i] = (m_p[i] + 1 < lim - 1) ? m_p[i] + 1 : lim - 1;
            lim = m_p[i];
        end
        if (m_p.size() > 0 && m_p[0] == DEPTH) begin
            void'(m_p.pop_front());
            void'(m_d.pop_front());
        end
        if (acc) begin
            m_p.push_back(0);
            m_d.push_back(id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [WIDTH-1:0] v, input bit ordy);
        bit acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) step(1'b1, v, ordy, acc);
        if (!acc) chk("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit acc;
        for (int t = 0; t < DEPTH + 3; t++) step(1'b0, '0, 1'b1, acc);
        chk("drained", 32'(occupancy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        m_d.delete();
        m_p.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        logic [WIDTH-1:0] nxt;
        bit pend;
        do_reset();
        // streaming, no stall
        for (int j = 1; j <= 16; j++) feed(WIDTH'(j), 1'b1);
        drain();
        // backpressure fill and release
        for (int j = 0; j < 3; j++) feed(WIDTH'(8'hA0 + j), 1'b0);
        step(1'b1, 8'hA3, 1'b0, acc);
        chk("full_occ", 32'(occupancy), 32'd3);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out_data), 32'hA0);
        for (int j = 3; j < 6; j++) feed(WIDTH'(8'hA0 + j), 1'b1);
        drain();
        // bubble collapse
        feed(8'h55, 1'b1);
        feed(8'h66, 1'b0);
        feed(8'h77, 1'b0);
        step(1'b0, '0, 1'b0, acc);
        chk("collapse_occ", 32'(occupancy), 32'd3);
        drain();
        // full pipe with simultaneous in/out handshakes
        for (int j = 0; j < 3; j++) feed(WIDTH'(8'hC0 + j), 1'b0);
        for (int j = 0; j < 5; j++) begin
            step(1'b1, WIDTH'(8'hD0 + j), 1'b1, acc);
            chk("thru_acc", 32'(acc), 32'd1);
        end
        drain();
        // reset mid-stream
        feed(8'h11, 1'b0);
        feed(8'h22, 1'b0);
        do_reset();
        feed(8'h99, 1'b1);
        drain();
`ifdef STALL_PIPE_FLUSH_EN
        for (int j = 0; j < 3; j++) feed(WIDTH'(8'hE0 + j), 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        m_d.delete();
        m_p.delete();
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        feed(8'h42, 1'b1);
        drain();
`endif
        // random traffic obeying the producer rule
        pend = 1'b0;
        nxt = '0;
        for (int t = 0; t < 400; t++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                nxt = WIDTH'($urandom);
            end
            step(pend, nxt, 1'($urandom_range(0, 2) != 0), acc);
            if (acc) pend = 1'b0;
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
